// File: rtl/msg_uart_dump_if.sv
// Request, RAM read-port and serial-line bundle for msg_uart_dump.
// master drives requests and RAM data; slave is the dump engine.
interface msg_uart_dump_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, length, ram_rdata,
    input  ram_addr, tx, busy, done
  );

  modport slave (
    input  start, base_addr, length, ram_rdata,
    output ram_addr, tx, busy, done
  );
endinterface

// File: rtl/msg_uart_dump.sv
// Walks a RAM word range and sends the low byte of each word as UART 8N1 on tx.
// Defining MSG_UART_DUMP_PARITY_EN inserts an even-parity bit (8E1 framing).
module msg_uart_dump #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned LEN_W        = 11
) (
  input logic            clk,
  input logic            rst,
  msg_uart_dump_if.slave bus
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StStart, StData, StParity, StStop
  } state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              par_q, par_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              tx_q, tx_d;
  logic              zdone_q, zdone_d;
  logic              bit_last;
  logic              unused_rdata_hi;

  assign unused_rdata_hi = ^bus.ram_rdata[31:8];
  assign bit_last        = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BaudW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    zdone_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          rem_d  = bus.length;
          if (bus.length == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        // RAM data for the address presented in FETCH is valid now.
        sh_d    = bus.ram_rdata[7:0];
        par_d   = ^bus.ram_rdata[7:0];
        state_d = StStart;
      end
      StStart: begin
        if (bit_last) begin
          bit_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_last) begin
          sh_d = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef MSG_UART_DUMP_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_last) state_d = StStop;
      end
      StStop: begin
        if (bit_last) begin
          rem_d   = rem_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? StIdle : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bit timer restarts on every state entry.
    if (state_d != state_q || state_q == StIdle) baud_d = '0;

    // tx is registered: drive the level that belongs to the next cycle's state.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = sh_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      tx_q    <= 1'b1;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tx_q    <= tx_d;
      zdone_q <= zdone_d;
    end
  end

  assign bus.ram_addr = addr_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = zdone_q | ((state_q == StStop) && bit_last && (rem_q == LEN_W'(1)));

endmodule

// File: tb/tb_msg_uart_dump.sv
// Bench for msg_uart_dump: a line-level UART receiver and a RAM array form the
// reference; each scenario task checks its own expectations.
module tb_msg_uart_dump;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned AddrW = 10;
  localparam int unsigned LenW  = 11;
`ifdef MSG_UART_DUMP_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int WordCycles = 2 + FrameBits * Cpb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msg_uart_dump_if #(.ADDR_W(AddrW), .LEN_W(LenW)) bus ();

  msg_uart_dump #(.CLKS_PER_BIT(Cpb), .ADDR_W(AddrW), .LEN_W(LenW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [1024];
  always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr];

  int checks = 0;
  int errors = 0;

  // Line-level receiver: samples each bit in its second cycle.
  logic [7:0]  rx_q[$];
  logic [9:0]  addr_seen[$];
  int          fr_err = 0;
  int          rx_k = 0;
  logic        rx_on = 1'b0;
  logic        tx_prev = 1'b1;
  logic [10:0] rx_bits;

  always @(negedge clk) begin
    if (rst) begin
      rx_on   = 1'b0;
      tx_prev = 1'b1;
    end else begin
      if (!rx_on && tx_prev && !bus.tx) begin
        rx_on = 1'b1;
        rx_k  = 0;
      end
      if (rx_on) begin
        if (rx_k % Cpb == 1) rx_bits[rx_k / Cpb] = bus.tx;
        if (rx_k == (FrameBits - 1) * Cpb + 1) begin
          rx_on = 1'b0;
          if (rx_bits[0] !== 1'b0 || rx_bits[FrameBits-1] !== 1'b1) fr_err++;
`ifdef MSG_UART_DUMP_PARITY_EN
          if (rx_bits[9] !== ^rx_bits[8:1]) fr_err++;
`endif
          rx_q.push_back(rx_bits[8:1]);
        end
        rx_k++;
      end
      tx_prev = bus.tx;
    end
  end

  // Call just after a negedge; returns 1 ns after the accepting edge N.
  task automatic do_start(input logic [9:0] b, input logic [10:0] l);
    bus.start     = 1'b1;
    bus.base_addr = b;
    bus.length    = l;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = 10'($urandom);
    bus.length    = 11'($urandom);
  endtask

  // Waits for done (k counts cycles after edge N), logging addresses issued while busy.
  task automatic wait_done(input int budget, output int kd);
    kd = 0;
    addr_seen.delete();
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.busy && (addr_seen.size() == 0 || addr_seen[$] != bus.ram_addr))
        addr_seen.push_back(bus.ram_addr);
      if (bus.done) begin
        kd = k;
        break;
      end
    end
    if (kd == 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done, required done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.ram_addr !== 10'd0) begin
      errors++; $display("FAIL reset_addr: got %0d want 0", bus.ram_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [10:0] fr;
    int kd = 0, ndone = 0, bad = 0, first_bad = -1;
    logic busy_after = 1'b1;
    logic addr1 = 1'b0, busy1 = 1'b0;
    mem[5] = 32'h0000_0041;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = 8'h41;
`ifdef MSG_UART_DUMP_PARITY_EN
    fr[9] = ^fr[8:1];
`endif
    rx_q.delete();
    do_start(10'd5, 11'd1);
    for (int k = 1; k <= WordCycles + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin addr1 = (bus.ram_addr === 10'd5); busy1 = bus.busy; end
      if (k >= 3 && k <= WordCycles && bus.tx !== fr[(k - 3) / Cpb]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (bus.done === 1'b1) begin ndone++; if (kd == 0) kd = k; end
      if (k == WordCycles + 1) busy_after = bus.busy;
    end
    checks++; if (!addr1) begin errors++; $display("FAIL single_addr: ram_addr not 5 at N+1"); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy1); end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL single_tx_seq: %0d wrong cycles, first at N+%0d, want 0 wrong", bad, first_bad);
    end
    checks++; if (kd != WordCycles || ndone != 1) begin
      errors++; $display("FAIL single_done: got N+%0d x%0d want N+%0d x1", kd, ndone, WordCycles);
    end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy_after); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
      errors++; $display("FAIL single_byte: got %0d bytes want 1 byte 0x41", rx_q.size());
    end
  endtask

  task automatic test_wrap();
    string exp = "Hol";
    int kd, extra = 0, bad = 0;
    mem[1022] = 32'h48; mem[1023] = 32'h6F; mem[0] = 32'h6C;
    rx_q.delete();
    @(negedge clk);
    do_start(10'd1022, 11'd3);
    wait_done(3 * WordCycles + 10, kd);
    checks++; if (kd != 3 * WordCycles) begin
      errors++; $display("FAIL wrap_done: got N+%0d want N+%0d", kd, 3 * WordCycles);
    end
    checks++;
    if (addr_seen.size() != 3) bad++;
    else for (int i = 0; i < 3; i++) if (addr_seen[i] !== 10'((1022 + i) % 1024)) bad++;
    if (bad != 0) begin errors++; $display("FAIL wrap_addr: %0d addresses wrong, want 1022,1023,0", bad); end
    bad = 0;
    checks++;
    if (rx_q.size() != 3) bad++;
    else for (int i = 0; i < 3; i++) if (rx_q[i] !== exp[i]) bad++;
    if (bad != 0) begin errors++; $display("FAIL wrap_bytes: %0d bytes wrong of %0d, want Hol", bad, rx_q.size()); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL wrap_single_done: got %0d busy/done cycles after done want 0", extra); end
  endtask

  task automatic test_zero_length();
    int noisy = 0;
    @(negedge clk);
    do_start(10'd0, 11'd0);
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
      errors++; $display("FAIL zero_idle: busy %b tx %b want 0 1", bus.busy, bus.tx);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tx !== 1'b1) noisy++;
    end
    checks++; if (noisy != 0) begin errors++; $display("FAIL zero_quiet: got %0d active cycles want 0", noisy); end
  endtask

  task automatic test_start_while_busy();
    int kd = 0, bad = 0;
    mem[10] = $urandom; mem[11] = $urandom; mem[20] = $urandom;
    rx_q.delete();
    addr_seen.delete();
    @(negedge clk);
    do_start(10'd10, 11'd2);
    for (int k = 1; k <= 2 * WordCycles + 10; k++) begin
      @(negedge clk);
      if (bus.busy && (addr_seen.size() == 0 || addr_seen[$] != bus.ram_addr))
        addr_seen.push_back(bus.ram_addr);
      bus.start = (k == 20);
      if (k == 20) begin bus.base_addr = 10'd100; bus.length = 11'd5; end
      if (bus.done) begin kd = k; break; end
    end
    // Request in the done cycle itself must be dropped.
    bus.start = 1'b1; bus.base_addr = 10'd200; bus.length = 11'd1;
    checks++; if (kd != 2 * WordCycles) begin
      errors++; $display("FAIL busy_done: got N+%0d want N+%0d", kd, 2 * WordCycles);
    end
    checks++;
    if (addr_seen.size() != 2 || addr_seen[0] !== 10'd10 || addr_seen[1] !== 10'd11) bad++;
    if (rx_q.size() != 2 || rx_q[0] !== mem[10][7:0] || rx_q[1] !== mem[11][7:0]) bad++;
    if (bad != 0) begin errors++; $display("FAIL busy_ignore: got %0d addrs %0d bytes want 10,11 and 2 bytes", addr_seen.size(), rx_q.size()); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start: got busy %b want 0", bus.busy); end
    rx_q.delete();
    do_start(10'd20, 11'd1);
    wait_done(WordCycles + 10, kd);
    checks++; if (kd != WordCycles || addr_seen.size() != 1 || addr_seen[0] !== 10'd20) begin
      errors++; $display("FAIL after_done_start: got done N+%0d addrs %0d want N+%0d addr 20", kd, addr_seen.size(), WordCycles);
    end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== mem[20][7:0]) begin
      errors++; $display("FAIL after_done_byte: got %0d bytes want 1 byte %h", rx_q.size(), mem[20][7:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int kd, stray = 0;
    mem[7] = $urandom;
    b = mem[7][7:0];
    rx_q.delete();
    @(negedge clk);
    do_start(10'd7, 11'd1);
    repeat (19) @(negedge clk);
    checks++; if (bus.tx !== b[3]) begin errors++; $display("FAIL rst_bit3: got %b want %b", bus.tx, b[3]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL rst_mid: tx %b busy %b done %b want 1 0 0", bus.tx, bus.busy, bus.done);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++; if (stray != 0 || rx_q.size() != 0) begin
      errors++; $display("FAIL rst_no_done: got %0d stray cycles %0d bytes want 0 0", stray, rx_q.size());
    end
    do_start(10'd7, 11'd1);
    wait_done(WordCycles + 10, kd);
    checks++; if (kd != WordCycles || rx_q.size() != 1 || rx_q[0] !== b) begin
      errors++; $display("FAIL rst_restart: got done N+%0d %0d bytes want N+%0d byte %h", kd, rx_q.size(), WordCycles, b);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int base = $urandom_range(0, 1023);
      int len  = $urandom_range(1, 4);
      int kd, bad = 0;
      for (int i = 0; i < len; i++) mem[(base + i) % 1024] = $urandom;
      rx_q.delete();
      repeat ($urandom_range(1, 3)) @(negedge clk);
      do_start(10'(base), 11'(len));
      wait_done(len * WordCycles + 10, kd);
      if (addr_seen.size() != len || rx_q.size() != len) bad++;
      else for (int i = 0; i < len; i++) begin
        if (addr_seen[i] !== 10'((base + i) % 1024)) bad++;
        if (rx_q[i] !== mem[(base + i) % 1024][7:0]) bad++;
      end
      checks++; if (kd != len * WordCycles || bad != 0) begin
        errors++; $display("FAIL random_%0d: base %0d len %0d done N+%0d want N+%0d, %0d wrong items",
                           t, base, len, kd, len * WordCycles, bad);
      end
    end
    checks++; if (fr_err != 0) begin errors++; $display("FAIL framing: got %0d bad frames want 0", fr_err); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FF00 | 32'(i);
    test_reset();
    test_single_word();
    test_wrap();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_uart_dump.md
# msg_uart_dump

Read-out engine for the decoded-message region of data memory. After the CPU has written the decoded text into RAM, this block walks a word range, takes the low byte of each 32-bit word, and transmits it serially as UART 8N1 on `tx`. It is the reader counterpart to the CPU's write path into RAM. It owns the RAM read port while `busy` is high.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit; legal range ≥ 2.
- `ADDR_W`, default 10: RAM word-address width.
- `LEN_W`, default 11: width of the word count.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a dump; sampled only in IDLE.
- `base_addr` input ADDR_W: first word address; captured when `start` is accepted.
- `length` input LEN_W: number of words to send; captured when `start` is accepted.
- `ram_addr` output ADDR_W: registered read address driven to RAM.
- `ram_rdata` input 32: RAM read data, valid 1 cycle after `ram_addr`; only bits [7:0] are used.
- `tx` output 1: serial line; idles high.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse when the dump completes.

## Operation
- **States:** IDLE, FETCH, WAIT, START, DATA, PARITY (only with the macro), STOP.
- **IDLE**
  - `start`=1 latches `base_addr` into the address counter and `length` into the remaining counter.
  - If `length`==0: go to IDLE and pulse `done` on the next cycle. No RAM access and no `tx` activity.
  - Otherwise go to FETCH.
- **FETCH:** `ram_addr` = address counter. Next state is WAIT.
- **WAIT:** at the end of this cycle, `ram_rdata[7:0]` is loaded into the 8-bit shift register. Next state is START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles.
- **DATA:** 8 bits, LSB first. Each bit is held for CLKS_PER_BIT cycles. A 3-bit bit index counts 0..7.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles. At the last STOP cycle:
  - Decrement the remaining counter.
  - Increment the address counter, modulo 2^ADDR_W (1023 wraps to 0).
  - If remaining becomes 0: go to IDLE and pulse `done` in the same cycle.
  - Otherwise go to FETCH.
- **Ignored requests:** `start` is ignored while `busy`=1, including in the same cycle as `done`. A new dump may be accepted the cycle after `done`.
- **Captured inputs:** changes to `base_addr` and `length` while busy have no effect.
- **Bit timer:** a baud counter counts 0..CLKS_PER_BIT-1 and resets on every state entry.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `done`=0, `ram_addr`=0. The state is IDLE and all counters are 0.
- **Reset mid-operation:** takes effect on the next edge.
  - `tx` returns to 1 immediately. This may truncate a frame.
  - No `done` is produced.
- **Start of a dump** (start accepted at edge N):
  - `busy`=1 from cycle N+1.
  - FETCH is cycle N+1. WAIT is cycle N+2.
  - The start bit begins at cycle N+3.
- **Per-word cost:** 2 + 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- **Completion:** `done` coincides with the last STOP cycle. `busy` drops the cycle after `done`.
- **Zero length:** `done` at N+1; `busy` stays 0.
- **Bit boundaries:** `tx` changes only at bit boundaries and is glitch-free, because it is driven from a register.

## Configuration
- `MSG_UART_DUMP_PARITY_EN`
  - **Defined:** a PARITY state is inserted between DATA and STOP. `tx` carries the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame becomes 8E1 and is 11 bit-times.
  - **Undefined:** there is no PARITY state. DATA goes directly to STOP, giving 8N1 and 10 bit-times.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- **Reset:** hold `rst` for 3 cycles → `tx`=1, `busy`=0, `done`=0, `ram_addr`=0.
- **Single word:** RAM[5]=0x0000_0041, start with base=5, length=1.
  - `ram_addr`=5 at N+1.
  - `tx` sequence from N+3, 4 cycles per bit: 0,1,0,0,0,0,0,1,0,1.
  - `done` at N+42. Total 42 cycles, or 46 with parity (parity bit 0).
- **Multi-word and wrap:** RAM[1022..1023,0]=0x48,0x6F,0x6C; base=1022, length=3.
  - `ram_addr` sequence is 1022, 1023, 0.
  - Decoded bytes are "Hol"; exactly one `done` pulse.
- **Zero length:** base=0, length=0 → `done` at N+1; `busy` stays 0; `tx` stays 1.
- **Start while busy:** pulse `start` mid-DATA with new base=100 → ignored; no address 100 is issued. A start the cycle after `done` is accepted.
- **Reset mid-frame:** assert `rst` during the DATA bit 3 cycle → `tx`=1 next cycle, `busy`=0, no `done`. A following start with length=1 works normally.
